// File: rtl/ras_spec_pkg.sv
// Shared types and sizing helpers for the return-address stack and its
// pointer checkpoints.
package ras_spec_pkg;

  localparam int unsigned CVA6ConfigRASDepth = 32'd2;
  localparam int unsigned CVA6ConfigXlen     = 32'd32;

  // Sized for the largest legal DEPTH (64) so one struct serves every build.
  typedef struct packed {
    logic [5:0] tos;
    logic [6:0] count;
  } ras_ckpt_t;

  function automatic int unsigned ras_cnt_w(input int unsigned depth);
    return $clog2(depth + 32'd1);
  endfunction

  function automatic int unsigned ras_tos_w(input int unsigned depth);
    return (depth > 32'd1) ? $clog2(depth) : 32'd1;
  endfunction

  function automatic int unsigned ras_idx_w(input int unsigned nr_ckpt);
    return (nr_ckpt > 32'd1) ? $clog2(nr_ckpt) : 32'd1;
  endfunction

endpackage

// File: rtl/ras_ckpt_store.sv
// Checkpoint slot array: one write port, one combinational read port, flush clear.
// The read returns the pre-write value, so a same-slot save/restore sees the old slot.
module ras_ckpt_store
  import ras_spec_pkg::*;
#(
  parameter int unsigned NR_CKPT = 32'd4,
  localparam int unsigned IW = ras_idx_w(NR_CKPT)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          we_i,
  input  logic [IW-1:0] widx_i,
  input  ras_ckpt_t     wdata_i,
  input  logic [IW-1:0] ridx_i,
  output ras_ckpt_t     rdata_o
);

  ras_ckpt_t slot_q [NR_CKPT];
  ras_ckpt_t slot_d [NR_CKPT];

  always_comb begin
    slot_d = slot_q;
    if (flush_i) begin
      for (int i = 0; i < int'(NR_CKPT); i++) begin
        slot_d[i] = '0;
      end
    end else if (we_i && (32'(widx_i) < NR_CKPT)) begin
      slot_d[widx_i] = wdata_i;
    end else begin
      slot_d = slot_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NR_CKPT); i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      slot_q <= slot_d;
    end
  end

  assign rdata_o = (32'(ridx_i) < NR_CKPT) ? slot_q[ridx_i] : '0;

endmodule

// File: rtl/ras_spec.sv
// Circular return-address stack with saturating occupancy, overwrite-on-full
// and tos/count checkpoint save/restore for speculative recovery.
module ras_spec
  import ras_spec_pkg::*;
#(
  parameter int unsigned DEPTH   = CVA6ConfigRASDepth,
  parameter int unsigned VLEN    = CVA6ConfigXlen,
  parameter int unsigned NR_CKPT = 32'd4,
  localparam int unsigned IW = ras_idx_w(NR_CKPT),
  localparam int unsigned CW = ras_cnt_w(DEPTH),
  localparam int unsigned TW = ras_tos_w(DEPTH)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            push_i,
  input  logic [VLEN-1:0] addr_i,
  input  logic            pop_i,
  input  logic            ckpt_save_i,
  input  logic [IW-1:0]   ckpt_sidx_i,
  input  logic            ckpt_restore_i,
  input  logic [IW-1:0]   ckpt_ridx_i,
  output logic [VLEN-1:0] top_o,
  output logic            top_valid_o,
  output logic [CW-1:0]   count_o,
  output logic            overflow_o
);

  logic [TW-1:0]   tos_q, tos_d, tos_inc, tos_dec;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [VLEN-1:0] entry_q [DEPTH];
  logic [VLEN-1:0] entry_d [DEPTH];
  ras_ckpt_t       ckpt_wdata, ckpt_rdata;
  logic            full, empty;

  assign tos_inc = (tos_q == TW'(DEPTH - 32'd1)) ? '0 : tos_q + TW'(1);
  assign tos_dec = (tos_q == '0) ? TW'(DEPTH - 32'd1) : tos_q - TW'(1);
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);

  // Saves always see the registered state from before this cycle's update.
  assign ckpt_wdata = '{tos: 6'(tos_q), count: 7'(count_q)};

  ras_ckpt_store #(.NR_CKPT(NR_CKPT)) u_ckpt_store (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .we_i    (ckpt_save_i),
    .widx_i  (ckpt_sidx_i),
    .wdata_i (ckpt_wdata),
    .ridx_i  (ckpt_ridx_i),
    .rdata_o (ckpt_rdata)
  );

  always_comb begin
    tos_d   = tos_q;
    count_d = count_q;
    ovf_d   = 1'b0;
    entry_d = entry_q;
    if (flush_i) begin
      tos_d   = '0;
      count_d = '0;
    end else if (ckpt_restore_i) begin
      tos_d   = TW'(ckpt_rdata.tos);
      count_d = CW'(ckpt_rdata.count);
    end else if (push_i && pop_i && !empty) begin
      entry_d[tos_q] = addr_i;
    end else if (push_i) begin
      tos_d            = tos_inc;
      entry_d[tos_inc] = addr_i;
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        count_d = count_q + CW'(1);
      end
    end else if (pop_i && !empty) begin
      tos_d   = tos_dec;
      count_d = count_q - CW'(1);
    end else begin
      tos_d = tos_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tos_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      tos_q   <= tos_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      entry_q <= entry_d;
    end
  end

  assign top_o       = entry_q[tos_q];
  assign top_valid_o = !empty;
  assign count_o     = count_q;
  assign overflow_o  = ovf_q;

endmodule
